data_mem_mmio: RTL and testbench

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/txq_fifo.sv | 33 +++
 rtl/data_mem_mmio.sv | 78 +++++++
 tb/tb_data_mem_mmio.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: MMIO address map, STATUS bit positions, RV32I load/store funct3 codes and the load formatter
package riscv_pkg;
  localparam logic [31:0] CNT_LO_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] CNT_HI_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_000C;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 3;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
           f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
           f3 == F3_W  ? s :
           f3 == F3_BU ? {24'b0, s[7:0]} :
           f3 == F3_HU ? {16'b0, s[15:0]} : 32'b0;
  endfunction
endpackage

// File: rtl/txq_fifo.sv
// txq_fifo: byte FIFO; clk/reset, push+wdata in, pop in, rdata is the head byte, count is the occupancy
module txq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] buffer [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic acc;
  assign acc = push && (count != CW'(DEPTH) || pop);
  assign rdata = buffer[rd_ptr];
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (acc) begin
        buffer[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(acc) - CW'(pop);
    end
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: RAM + counter/TX-FIFO MMIO; clk/reset, MemWrite/Mem_WrAddr/Mem_WrData/funct3 -> ReadData, tx_data/tx_valid/tx_ready stream, sticky misalign_err
module data_mem_mmio
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int TXQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  logic [31:0] ram [DEPTH_WORDS];
  logic [63:0] cnt;
  logic [CW-1:0] count;
  logic ovf, full, ram_hit, mis, ld_ok, st_ok, st, push, pop;
  logic [29:0] wa;
  logic [31:0] word, status, wd;
  logic [3:0] be;
  assign wa = Mem_WrAddr[31:2];
  assign ram_hit = Mem_WrAddr < 32'(DEPTH_WORDS * 4);
  assign ld_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign st_ok = funct3 inside {F3_B, F3_H, F3_W};
  assign mis = (funct3[1:0] == 2'b01 && Mem_WrAddr[0]) || (funct3[1:0] == 2'b10 && Mem_WrAddr[1:0] != 2'b00);
  assign st = MemWrite && st_ok && !mis;
  assign full = count == CW'(TXQ_DEPTH);
  assign tx_valid = count != '0;
  assign pop = tx_valid && tx_ready;
  assign push = st && wa == TXDATA_ADDR[31:2];
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = !tx_valid;
    status[ST_OVF] = ovf;
    status[ST_CNT +: 4] = 4'(count);
  end
  assign word = ram_hit ? ram[Mem_WrAddr[AW+1:2]] :
                wa == CNT_LO_ADDR[31:2] ? cnt[31:0] :
                wa == CNT_HI_ADDR[31:2] ? cnt[63:32] :
                wa == STATUS_ADDR[31:2] ? status : '0;
  assign ReadData = ld_ok && !mis ? load_fmt(word, Mem_WrAddr[1:0], funct3) : '0;
  assign wd = Mem_WrData << {Mem_WrAddr[1:0], 3'b000};
  assign be = funct3[1:0] == 2'b00 ? 4'b0001 << Mem_WrAddr[1:0] :
              funct3[1:0] == 2'b01 ? 4'b0011 << Mem_WrAddr[1:0] : 4'b1111;
  always_ff @(posedge clk)
    if (!reset && st && ram_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[Mem_WrAddr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      cnt <= cnt + 64'd1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (st && wa == STATUS_ADDR[31:2] && Mem_WrData[ST_OVF]) ovf <= 1'b0;
      if (mis && (MemWrite ? st_ok : ld_ok)) misalign_err <= 1'b1;
    end
  txq_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk),
    .reset(reset),
    .push(push),
    .wdata(Mem_WrData[7:0]),
    .pop(pop),
    .rdata(tx_data),
    .count(count)
  );
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: randomized and directed checks of data_mem_mmio against a byte-level reference model
module tb_data_mem_mmio;
  localparam int D = 64;
  localparam int Q = 4;
  localparam logic [31:0] A_CL = 32'hFFFF_0000;
  localparam logic [31:0] A_CH = 32'hFFFF_0004;
  localparam logic [31:0] A_TX = 32'hFFFF_0008;
  localparam logic [31:0] A_ST = 32'hFFFF_000C;
  logic clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, tx_ready = 1'b0;
  logic [31:0] Mem_WrAddr = '0, Mem_WrData = '0;
  logic [2:0] funct3 = 3'b010;
  logic [31:0] ReadData;
  logic [7:0] tx_data;
  logic tx_valid, misalign_err;
  int checks = 0, failures = 0;
  logic [7:0] m_ram [D*4];
  bit m_known [D*4];
  logic [63:0] m_cnt = '0;
  logic [7:0] m_q [$];
  bit m_ovf = 0, m_err = 0, armed = 0;
  logic [7:0] drain_exp [4] = '{8'h51, 8'h52, 8'h53, 8'h55};
  data_mem_mmio #(.DEPTH_WORDS(D), .TXQ_DEPTH(Q)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData),
    .funct3(funct3),
    .ReadData(ReadData),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int ld_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction
  function automatic int st_size(input logic [2:0] f);
    return f == 3'd0 ? 1 : f == 3'd1 ? 2 : f == 3'd2 ? 4 : 0;
  endfunction
  function automatic logic [31:0] reg_word(input logic [31:0] a);
    int n;
    n = m_q.size();
    if (a == A_CL) return m_cnt[31:0];
    if (a == A_CH) return m_cnt[63:32];
    if (a == A_ST) return 32'(n) * 8 + (m_ovf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == Q ? 1 : 0);
    return 0;
  endfunction
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f, output bit known);
    int n;
    logic [31:0] v, ai;
    logic [7:0] b;
    known = 1;
    n = ld_size(f);
    v = 0;
    if (n == 0 || a % n != 0) return 0;
    for (int i = 0; i < n; i++) begin
      ai = a + i;
      if (ai < D * 4) begin
        b = m_ram[ai];
        known &= m_known[ai];
      end else b = 8'(reg_word(ai & ~32'h3) >> (8 * (ai % 4)));
      v |= 32'(b) << (8 * i);
    end
    if ((f == 3'd0 || f == 3'd1) && v[8*n-1]) v |= ~32'h0 << (8 * n);
    return v;
  endfunction
  task automatic model();
    int n;
    bit pop;
    if (reset) begin
      m_cnt = 0;
      m_q.delete();
      m_ovf = 0;
      m_err = 0;
      armed = 1;
      return;
    end
    m_cnt++;
    pop = m_q.size() != 0 && tx_ready;
    if (MemWrite) begin
      n = st_size(funct3);
      if (n != 0 && Mem_WrAddr % n != 0) m_err = 1;
      else if (n != 0) begin
        if (Mem_WrAddr < D * 4)
          for (int i = 0; i < n; i++) begin
            m_ram[Mem_WrAddr + i] = Mem_WrData[8*i +: 8];
            m_known[Mem_WrAddr + i] = 1;
          end
        else if ((Mem_WrAddr & ~32'h3) == A_TX) begin
          if (m_q.size() < Q || pop) m_q.push_back(Mem_WrData[7:0]);
          else m_ovf = 1;
        end else if ((Mem_WrAddr & ~32'h3) == A_ST && Mem_WrData[2]) m_ovf = 0;
      end
    end else begin
      n = ld_size(funct3);
      if (n != 0 && Mem_WrAddr % n != 0) m_err = 1;
    end
    if (pop) void'(m_q.pop_front());
  endtask
  task automatic tick();
    bit k;
    logic [31:0] e;
    #1;
    if (armed) begin
      e = exp_load(Mem_WrAddr, funct3, k);
      if (k) check("rdata", ReadData, e);
      check("tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
      check("misalign", misalign_err, m_err);
    end
    model();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input bit rdy);
    MemWrite = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
    funct3 = f;
    tx_ready = rdy;
    tick();
  endtask
  task automatic ld_expect(input string tag, input logic [31:0] a, input logic [2:0] f, input logic [31:0] c, input bit rdy);
    MemWrite = 0;
    Mem_WrAddr = a;
    Mem_WrData = 0;
    funct3 = f;
    tx_ready = rdy;
    #1;
    check(tag, ReadData, c);
    tick();
  endtask
  initial begin
    reset = 1;
    drive(0, 0, 0, 3'd2, 0);
    drive(0, 0, 0, 3'd2, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_err", misalign_err, 0);
    reset = 0;
    repeat (10) drive(0, 0, 0, 3'd2, 0);
    ld_expect("cnt_lo_10", A_CL, 3'd2, 32'd10, 0);
    for (int i = 0; i < D; i++) drive(1, 32'(4 * i), $urandom, 3'd2, 0);
    drive(1, 32'h10, 32'h8765_4321, 3'd2, 0);
    ld_expect("lb10", 32'h10, 3'd0, 32'h0000_0021, 0);
    ld_expect("lbu10", 32'h10, 3'd4, 32'h0000_0021, 0);
    ld_expect("lh10", 32'h10, 3'd1, 32'h0000_4321, 0);
    ld_expect("lhu10", 32'h10, 3'd5, 32'h0000_4321, 0);
    ld_expect("lw10", 32'h10, 3'd2, 32'h8765_4321, 0);
    ld_expect("lb13", 32'h13, 3'd0, 32'hFFFF_FF87, 0);
    drive(1, 32'h12, 32'hAA, 3'd0, 0);
    ld_expect("sb12", 32'h10, 3'd2, 32'h87AA_4321, 0);
    for (int i = 0; i < 5; i++) drive(1, A_TX, 32'h41 + i, 3'd2, 0);
    ld_expect("status_ovf", A_ST, 3'd2, 32'h25, 0);
    for (int i = 0; i < 4; i++) begin
      MemWrite = 0;
      Mem_WrAddr = 0;
      funct3 = 3'd2;
      tx_ready = 1;
      #1;
      check("drain_ovf", tx_data, 8'h41 + 8'(i));
      tick();
    end
    drive(1, A_ST, 32'h4, 3'd2, 0);
    ld_expect("status_clr", A_ST, 3'd2, 32'h02, 0);
    for (int i = 0; i < 4; i++) drive(1, A_TX, 32'h50 + i, 3'd2, 0);
    drive(1, A_TX, 32'h55, 3'd2, 1);
    ld_expect("status_pp", A_ST, 3'd2, 32'h21, 0);
    for (int i = 0; i < 4; i++) begin
      MemWrite = 0;
      Mem_WrAddr = 0;
      funct3 = 3'd2;
      tx_ready = 1;
      #1;
      check("drain_pp", tx_data, drain_exp[i]);
      tick();
    end
    for (int t = 0; t < 400; t++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = r < 6 ? 32'($urandom_range(0, D * 4 - 1)) : r == 6 ? A_TX + 32'($urandom_range(0, 3)) :
          r == 7 ? A_ST : r == 8 ? ($urandom_range(0, 1) == 1 ? A_CL : A_CH) : $urandom;
      reset = $urandom_range(0, 99) == 0;
      drive(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    reset = 1;
    drive(0, 0, 0, 3'd2, 0);
    reset = 0;
    drive(1, 32'h11, 32'hBEEF, 3'd1, 0);
    check("mis_set", misalign_err, 1);
    repeat (5) begin
      drive(0, 32'h10, 0, 3'd2, 0);
      check("mis_hold", misalign_err, 1);
    end
    reset = 1;
    drive(0, 0, 0, 3'd2, 0);
    reset = 0;
    check("mis_rst", misalign_err, 0);
    for (int i = 0; i < 3; i++) drive(1, A_TX, 32'h60 + i, 3'd2, 0);
    drive(0, 0, 0, 3'd2, 1);
    reset = 1;
    drive(0, 0, 0, 3'd2, 1);
    reset = 0;
    check("rst_drain_txv", tx_valid, 0);
    ld_expect("rst_drain_cnt", A_CL, 3'd2, 32'd0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
